rat_checkpoint_mgr: RTL and testbench

RAT_CHECKPOINT_MGR -- requirements
Module: rat_checkpoint_mgr

---
 rtl/rat_checkpoint_mgr_pkg.sv | 12 +
 rtl/rat_checkpoint_mgr_slot_ram.sv | 38 +++
 rtl/rat_checkpoint_mgr.sv | 106 ++++++++++
 tb/tb_rat_checkpoint_mgr.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/rat_checkpoint_mgr_pkg.sv
// rtl/rat_checkpoint_mgr_pkg.sv - shared defaults and pointer type for the RAT checkpoint manager
package rat_checkpoint_mgr_pkg;

  localparam int CP_DEPTH_DEF = 8;
  localparam int ARF_SIZE_DEF = 32;
  localparam int PRF_SIZE_DEF = 64;

  // Checkpoint pointer: slot index plus one wrap bit above it
  localparam int CP_PTR_W = $clog2(CP_DEPTH_DEF) + 1;
  typedef logic [CP_PTR_W-1:0] cp_ptr_t;

endpackage

// File: rtl/rat_checkpoint_mgr_slot_ram.sv
// rtl/rat_checkpoint_mgr_slot_ram.sv - checkpoint slot storage, one write port and one registered read port
module cp_slot_ram #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             i_we,
  input  logic [AW-1:0]    i_waddr,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic             i_re,
  input  logic [AW-1:0]    i_raddr,
  output logic [WIDTH-1:0] o_rdata
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [WIDTH-1:0] r_rdata;

  // Storage array is never cleared; stale contents are unreachable once pointers reset
  always_ff @(posedge clock) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  // Read register only loads on a read so the restored value is held between restores
  always_ff @(posedge clock) begin
    if (reset) begin
      r_rdata <= '0;
    end else if (i_re) begin
      r_rdata <= r_mem[i_raddr];
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/rat_checkpoint_mgr.sv
// rtl/rat_checkpoint_mgr.sv - circular buffer of rename-map checkpoints with recover and release
module rat_checkpoint_mgr
  import rat_checkpoint_mgr_pkg::*;
#(
  parameter int CP_DEPTH = CP_DEPTH_DEF,
  parameter int ARF_SIZE = ARF_SIZE_DEF,
  parameter int PRF_SIZE = PRF_SIZE_DEF,
  parameter int PIDX_W   = $clog2(PRF_SIZE),
  parameter int CIDX_W   = $clog2(CP_DEPTH)
) (
  input  logic                             clock,
  input  logic                             reset,
  input  logic                             alloc_valid,
  output logic                             alloc_ready,
  output logic [CIDX_W-1:0]                alloc_idx,
  input  logic [ARF_SIZE-1:0][PIDX_W-1:0]  map_in,
  input  logic [PRF_SIZE-1:0]              pvalid_in,
  input  logic                             recover_valid,
  input  logic [CIDX_W-1:0]                recover_idx,
  output logic                             restore_valid,
  output logic [ARF_SIZE-1:0][PIDX_W-1:0]  map_out,
  output logic [PRF_SIZE-1:0]              pvalid_out,
  input  logic                             release_valid,
  output logic                             recover_err,
  output logic [CIDX_W:0]                  count
);

  localparam int SLOT_W = ARF_SIZE * PIDX_W + PRF_SIZE;
  localparam logic [CIDX_W:0] PTR_ONE    = {{CIDX_W{1'b0}}, 1'b1};
  localparam logic [CIDX_W:0] FULL_COUNT = {1'b1, {CIDX_W{1'b0}}};

  logic [CIDX_W:0]   r_head;
  logic [CIDX_W:0]   r_tail;
  logic              r_restore_valid;
  logic              r_recover_err;

  logic [CIDX_W:0]   w_count;
  logic [CIDX_W-1:0] w_offset;
  logic              w_live;
  logic              w_alloc_fire;
  logic              w_release_fire;
  logic              w_recover_ok;
  logic [CIDX_W:0]   w_rec_tail;
  logic [SLOT_W-1:0] w_rdata;

  // Occupancy and liveness derived purely from registered pointers
  always_comb begin
    w_count        = r_tail - r_head;
    w_offset       = recover_idx - r_head[CIDX_W-1:0];
    w_live         = ({1'b0, w_offset} < w_count);
    w_alloc_fire   = alloc_valid & alloc_ready & ~recover_valid;
    w_release_fire = release_valid & (w_count != '0);
    w_recover_ok   = recover_valid & w_live;
    // Recovering the slot being released in the same cycle leaves an empty buffer past it
    if (w_release_fire && (w_offset == '0)) begin
      w_rec_tail = r_head + PTR_ONE;
    end else begin
      w_rec_tail = r_head + {1'b0, w_offset};
    end
  end

  // Pointer updates and one-cycle status pulses; recover overrides any same-cycle alloc
  always_ff @(posedge clock) begin
    if (reset) begin
      r_head          <= '0;
      r_tail          <= '0;
      r_restore_valid <= 1'b0;
      r_recover_err   <= 1'b0;
    end else begin
      r_restore_valid <= w_recover_ok;
      r_recover_err   <= recover_valid & ~w_live;
      if (w_release_fire) begin
        r_head <= r_head + PTR_ONE;
      end
      if (w_recover_ok) begin
        r_tail <= w_rec_tail;
      end else if (w_alloc_fire) begin
        r_tail <= r_tail + PTR_ONE;
      end
    end
  end

  cp_slot_ram #(
    .WIDTH (SLOT_W),
    .DEPTH (CP_DEPTH),
    .AW    (CIDX_W)
  ) u_slot_ram (
    .clock   (clock),
    .reset   (reset),
    .i_we    (w_alloc_fire & ~reset),
    .i_waddr (r_tail[CIDX_W-1:0]),
    .i_wdata ({map_in, pvalid_in}),
    .i_re    (w_recover_ok & ~reset),
    .i_raddr (recover_idx),
    .o_rdata (w_rdata)
  );

  assign count         = w_count;
  assign alloc_ready   = (w_count != FULL_COUNT);
  assign alloc_idx     = r_tail[CIDX_W-1:0];
  assign restore_valid = r_restore_valid;
  assign recover_err   = r_recover_err;
  assign map_out       = w_rdata[SLOT_W-1:PRF_SIZE];
  assign pvalid_out    = w_rdata[PRF_SIZE-1:0];

endmodule

// File: tb/tb_rat_checkpoint_mgr.sv
// tb/tb_rat_checkpoint_mgr.sv - directed self-checking bench for rat_checkpoint_mgr
module tb_rat_checkpoint_mgr;

  localparam int CP_DEPTH = 8;
  localparam int ARF_SIZE = 32;
  localparam int PRF_SIZE = 64;
  localparam int PIDX_W   = 6;
  localparam int CIDX_W   = 3;

  logic                            clock;
  logic                            reset;
  logic                            alloc_valid;
  logic                            alloc_ready;
  logic [CIDX_W-1:0]               alloc_idx;
  logic [ARF_SIZE-1:0][PIDX_W-1:0] map_in;
  logic [PRF_SIZE-1:0]             pvalid_in;
  logic                            recover_valid;
  logic [CIDX_W-1:0]               recover_idx;
  logic                            restore_valid;
  logic [ARF_SIZE-1:0][PIDX_W-1:0] map_out;
  logic [PRF_SIZE-1:0]             pvalid_out;
  logic                            release_valid;
  logic                            recover_err;
  logic [CIDX_W:0]                 count;

  int n_cmp = 0;
  int n_err = 0;

  rat_checkpoint_mgr #(
    .CP_DEPTH (CP_DEPTH),
    .ARF_SIZE (ARF_SIZE),
    .PRF_SIZE (PRF_SIZE)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .alloc_valid   (alloc_valid),
    .alloc_ready   (alloc_ready),
    .alloc_idx     (alloc_idx),
    .map_in        (map_in),
    .pvalid_in     (pvalid_in),
    .recover_valid (recover_valid),
    .recover_idx   (recover_idx),
    .restore_valid (restore_valid),
    .map_out       (map_out),
    .pvalid_out    (pvalid_out),
    .release_valid (release_valid),
    .recover_err   (recover_err),
    .count         (count)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  function automatic logic [ARF_SIZE-1:0][PIDX_W-1:0] mk_map(input int v);
    logic [ARF_SIZE-1:0][PIDX_W-1:0] m;
    for (int a = 0; a < ARF_SIZE; a++) m[a] = PIDX_W'(v);
    return m;
  endfunction

  function automatic logic [PRF_SIZE-1:0] mk_pv(input int v);
    return {8{8'(v)}} ^ 64'hA5A5_0000_FFFF_1234;
  endfunction

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    alloc_valid   = 1'b0;
    recover_valid = 1'b0;
    recover_idx   = '0;
    release_valid = 1'b0;
  endtask

  initial begin
    idle();
    map_in    = '0;
    pvalid_in = '0;
    reset     = 1'b1;
    tick();
    tick();
    reset = 1'b0;

    chk("rst_count", count, 0);
    chk("rst_ready", alloc_ready, 1);
    chk("rst_alloc_idx", alloc_idx, 0);
    chk("rst_restore", restore_valid, 0);
    chk("rst_err", recover_err, 0);
    chk("rst_map", map_out, 0);
    chk("rst_pv", pvalid_out, 0);

    // Fill all eight slots
    for (int i = 0; i < 8; i++) begin
      alloc_valid = 1'b1;
      map_in      = mk_map(i);
      pvalid_in   = mk_pv(i);
      chk("fill_alloc_idx", alloc_idx, i);
      tick();
    end
    chk("full_count", count, 8);
    chk("full_ready", alloc_ready, 0);

    // Ninth alloc refused
    map_in    = mk_map(9);
    pvalid_in = mk_pv(9);
    tick();
    chk("ninth_count", count, 8);
    chk("ninth_alloc_idx", alloc_idx, 0);

    // Recover slot 3 from a full buffer
    idle();
    recover_valid = 1'b1;
    recover_idx   = 3'd3;
    tick();
    idle();
    chk("rec3_restore", restore_valid, 1);
    chk("rec3_map", map_out, mk_map(3));
    chk("rec3_pv", pvalid_out, mk_pv(3));
    chk("rec3_count", count, 3);
    chk("rec3_alloc_idx", alloc_idx, 3);
    chk("rec3_err", recover_err, 0);
    tick();
    chk("rec3_pulse_end", restore_valid, 0);
    chk("rec3_map_hold", map_out, mk_map(3));

    // Six alloc+release pairs to wrap the pointers; count stays 3
    for (int k = 0; k < 6; k++) begin
      alloc_valid   = 1'b1;
      release_valid = 1'b1;
      map_in        = mk_map(10 + k);
      pvalid_in     = mk_pv(10 + k);
      tick();
      chk("wrap_count", count, 3);
    end
    idle();
    chk("wrap_alloc_idx", alloc_idx, 1);

    // Live slots are 6,7,0 holding 13,14,15; recover wrapped slot 0
    recover_valid = 1'b1;
    recover_idx   = 3'd0;
    tick();
    idle();
    chk("recw_restore", restore_valid, 1);
    chk("recw_map", map_out, mk_map(15));
    chk("recw_pv", pvalid_out, mk_pv(15));
    chk("recw_count", count, 2);
    chk("recw_alloc_idx", alloc_idx, 0);

    // Slot 3 was freed long ago
    recover_valid = 1'b1;
    recover_idx   = 3'd3;
    tick();
    idle();
    chk("recdead_err", recover_err, 1);
    chk("recdead_restore", restore_valid, 0);
    chk("recdead_count", count, 2);
    chk("recdead_alloc_idx", alloc_idx, 0);
    chk("recdead_map_hold", map_out, mk_map(15));

    // Slot 0 is now one past the window as well
    recover_valid = 1'b1;
    recover_idx   = 3'd0;
    tick();
    idle();
    chk("rectail_err", recover_err, 1);
    chk("rectail_count", count, 2);

    // Refill to eight: slots 0..5 get 20..25
    for (int k = 0; k < 6; k++) begin
      alloc_valid = 1'b1;
      map_in      = mk_map(20 + k);
      pvalid_in   = mk_pv(20 + k);
      tick();
    end
    idle();
    chk("refill_count", count, 8);
    chk("refill_alloc_idx", alloc_idx, 6);

    // Alloc + release while full: release only
    alloc_valid   = 1'b1;
    release_valid = 1'b1;
    map_in        = mk_map(50);
    tick();
    idle();
    chk("allocrel_full_count", count, 7);
    chk("allocrel_full_alloc_idx", alloc_idx, 6);

    // Alloc + recover of slot 1 (holds 21): alloc dropped
    alloc_valid   = 1'b1;
    map_in        = mk_map(30);
    pvalid_in     = mk_pv(30);
    recover_valid = 1'b1;
    recover_idx   = 3'd1;
    tick();
    idle();
    chk("allocrec_restore", restore_valid, 1);
    chk("allocrec_map", map_out, mk_map(21));
    chk("allocrec_count", count, 2);
    chk("allocrec_alloc_idx", alloc_idx, 1);

    // Release + recover at head (slot 7 holds 14): buffer ends empty
    release_valid = 1'b1;
    recover_valid = 1'b1;
    recover_idx   = 3'd7;
    tick();
    idle();
    chk("relrec_restore", restore_valid, 1);
    chk("relrec_map", map_out, mk_map(14));
    chk("relrec_pv", pvalid_out, mk_pv(14));
    chk("relrec_count", count, 0);
    chk("relrec_ready", alloc_ready, 1);

    // Release on empty ignored
    release_valid = 1'b1;
    tick();
    idle();
    chk("relempty_count", count, 0);

    // One live slot, then reset together with a legal recover
    alloc_valid = 1'b1;
    map_in      = mk_map(40);
    pvalid_in   = mk_pv(40);
    tick();
    idle();
    chk("pre_rst_count", count, 1);
    reset         = 1'b1;
    recover_valid = 1'b1;
    recover_idx   = 3'd0;
    tick();
    reset = 1'b0;
    idle();
    chk("rstrec_restore", restore_valid, 0);
    chk("rstrec_err", recover_err, 0);
    chk("rstrec_count", count, 0);
    chk("rstrec_ready", alloc_ready, 1);
    chk("rstrec_alloc_idx", alloc_idx, 0);
    chk("rstrec_map", map_out, 0);
    chk("rstrec_pv", pvalid_out, 0);
    tick();
    chk("rstrec_restore_late", restore_valid, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
